reg_mem_2r1w: RTL and testbench
===============================

REG_MEM_2R1W -- requirements
Module: reg_mem_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width in bits of each memory word.
REQ-002 The block SHALL have parameter ADDR_BITS, default 5, meaning the address width; DEPTH = 2**ADDR_BITS entries (32 at default).
REQ-003 The block SHALL have parameter INIT_VALUE, default 0, meaning the DATA_WIDTH-bit value loaded into every entry by the reset clear sequence.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port wen, input, 1 bit: write enable.
REQ-008 The block SHALL have port waddr, input, ADDR_BITS bits: write address.
REQ-009 The block SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-010 The block SHALL have port raddr_a, input, ADDR_BITS bits: port A read address.
REQ-011 The block SHALL have port raddr_b, input, ADDR_BITS bits: port B read address.
REQ-012 The block SHALL have port data_out_a, output, DATA_WIDTH bits: registered port A read data.
REQ-013 The block SHALL have port data_out_b, output, DATA_WIDTH bits: registered port B read data.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the clear sequence runs; reads and writes are ignored while it is high.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 A rising edge with reset=1 SHALL set the state to CLEAR, clear_ptr=0, busy=1, data_out_a=0 and data_out_b=0, from any state.
REQ-017 Each edge in CLEAR with reset=0 SHALL write INIT_VALUE to mem[clear_ptr] and increment clear_ptr.
REQ-018 The edge that writes entry DEPTH-1 SHALL move the state to READY and drive busy=0 from the next cycle, so busy stays high for exactly DEPTH cycles after reset deasserts.
REQ-019 An assertion of reset during CLEAR SHALL restart the sequence at clear_ptr=0.
REQ-020 In READY, an edge with wen=1 SHALL write data_in to mem[waddr].
REQ-021 While busy=1, wen SHALL be ignored: no user write occurs and data_out_a and data_out_b hold 0.
REQ-022 Reads SHALL be synchronous with one-cycle latency: on each edge in READY, data_out_a <= mem[raddr_a] and data_out_b <= mem[raddr_b].
REQ-023 Read bypass SHALL be write-first: if wen=1 and waddr==raddr_x on the same edge, data_out_x <= data_in.
REQ-024 Ports A and B SHALL be fully independent; equal addresses on A and B SHALL return identical data.
REQ-025 Every ADDR_BITS-bit address SHALL be valid; there is no out-of-range condition and no wrap logic.
REQ-026 An entry not written since the last clear sequence SHALL read INIT_VALUE.
REQ-027 Outputs SHALL change only on clk rising edges; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 Reset SHALL be sampled only on the clk rising edge; no asynchronous reset path SHALL exist.
REQ-029 While reset=1, busy=1 and data_out_a=data_out_b=0 SHALL hold on every edge.

Verification
REQ-030 Reset for 2 cycles, then release -> busy=1 for exactly 32 cycles, then 0; reads of addresses 0..31 all return 0x00.
REQ-031 After clear, write i to address i-10 for i=10..41, then read each address on A and B -> each returns address+10, one cycle after the address is applied.
REQ-032 With wen=1, waddr=7, data_in=0xA5, raddr_a=7, raddr_b=8 -> next cycle data_out_a=0xA5 (bypass) and data_out_b=the old mem[8].
REQ-033 wen=1, waddr=3, data_in=0x55 while busy=1 -> after clear completes, address 3 reads INIT_VALUE; with INIT_VALUE=0x3C, every address reads 0x3C.
REQ-034 Reset asserted for 1 cycle at clear cycle 20 -> busy remains high for 32 full cycles after the re-release, and no user write lands during that time.
REQ-035 Parameter sweep DATA_WIDTH=16, ADDR_BITS=3 -> busy lasts 8 cycles and writing/reading 0xBEEF to address 7 round-trips correctly.

Source files
------------

// File: rtl/reg_mem_2r1w.sv
// Two-read one-write register memory with a post-reset clear sequence; reads have 1-cycle latency with write-first bypass.
// Busy is asserted for DEPTH cycles after reset is released. While busy, writes are ignored and the read outputs hold zero.
module reg_mem_2r1w #(
    parameter int                     DATA_WIDTH = 8,
    parameter int                     ADDR_BITS  = 5,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_BITS-1:0]  raddr_a,
    input  logic [ADDR_BITS-1:0]  raddr_b,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [ADDR_BITS-1:0]   clear_ptr;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic                   user_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Leave CLEAR on the edge that initialises the last entry.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (&clear_ptr) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_ptr <= '0;
        end else if (state == CLEAR) begin
            clear_ptr <= clear_ptr + 1'b1;
        end
    end

    assign user_wr = (state == READY) && !reset && wen;

    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[clear_ptr] <= INIT_VALUE;
        end else if (user_wr) begin
            mem[waddr] <= data_in;
        end
    end

    // Write-first: a same-edge write to the read address is forwarded.
    always_ff @(posedge clk) begin
        if (reset || state == CLEAR) begin
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            data_out_a <= (wen && waddr == raddr_a) ? data_in : mem[raddr_a];
            data_out_b <= (wen && waddr == raddr_b) ? data_in : mem[raddr_b];
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Directed bench for reg_mem_2r1w: default, INIT_VALUE=0x3C and 16x8 instances.
module tb_reg_mem_2r1w;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [7:0]  data_in = '0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [7:0]  a0, b0, a1, b1;
    logic        busy0, busy1;

    logic        reset2 = 1'b1;
    logic        wen2 = 1'b0;
    logic [2:0]  waddr2 = '0;
    logic [15:0] din2 = '0;
    logic [2:0]  ra2 = '0;
    logic [2:0]  rb2 = '0;
    logic [15:0] a2, b2;
    logic        busy2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_mem_2r1w dut0 (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .data_in(data_in),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .data_out_a(a0), .data_out_b(b0), .busy(busy0)
    );

    reg_mem_2r1w #(.DATA_WIDTH(8), .ADDR_BITS(5), .INIT_VALUE(8'h3C)) dut1 (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .data_in(data_in),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .data_out_a(a1), .data_out_b(b1), .busy(busy1)
    );

    reg_mem_2r1w #(.DATA_WIDTH(16), .ADDR_BITS(3)) dut2 (
        .clk(clk), .reset(reset2), .wen(wen2), .waddr(waddr2), .data_in(din2),
        .raddr_a(ra2), .raddr_b(rb2),
        .data_out_a(a2), .data_out_b(b2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for two cycles, attempt a write to address 3 during clear, then sweep reads.
    task automatic test_reset();
        int cnt;
        reset = 1'b1;
        raddr_a = 5'd9;
        raddr_b = 5'd17;
        tick();
        tick();
        tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || a0 !== 8'h00 || b0 !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: busy=%b a=%h b=%h, required busy=1 a=00 b=00", busy0, a0, b0);
        end
        reset = 1'b0;
        wen = 1'b1;
        waddr = 5'd3;
        data_in = 8'h55;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 100) begin
            tests++;
            if (a0 !== 8'h00 || b0 !== 8'h00 || a1 !== 8'h00 || b1 !== 8'h00) begin
                fails++;
                $display("FAIL clear_outputs_zero: cycle %0d a0=%h b0=%h a1=%h b1=%h, required 00", cnt, a0, b0, a1, b1);
            end
            tick();
            cnt++;
        end
        wen = 1'b0;
        tests++;
        if (cnt !== 32 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL busy_length: %0d cycles (busy1=%b), required 32 cycles", cnt, busy1);
        end
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            tick();
            tests++;
            if (a0 !== 8'h00 || b0 !== 8'h00 || a1 !== 8'h3C || b1 !== 8'h3C) begin
                fails++;
                $display("FAIL init_read: addr %0d a0=%h b0=%h a1=%h b1=%h, required 00/00/3c/3c", i, a0, b0, a1, b1);
            end
        end
    endtask

    // Write i to address i-10 for i = 10..41, then read every address back on both ports.
    task automatic test_write_read();
        for (int i = 10; i <= 41; i++) begin
            wen = 1'b1;
            waddr = 5'(i - 10);
            data_in = 8'(i);
            tick();
        end
        wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(i);
            tick();
            tests++;
            if (a0 !== 8'(i + 10) || b0 !== 8'(i + 10) || a1 !== 8'(i + 10) || b1 !== 8'(i + 10)) begin
                fails++;
                $display("FAIL write_read: addr %0d a0=%h b0=%h a1=%h b1=%h, required %h", i, a0, b0, a1, b1, 8'(i + 10));
            end
        end
    endtask

    // Same-edge write and read of address 7 forwards the new data; port B sees the old address 8.
    task automatic test_bypass();
        wen = 1'b1;
        waddr = 5'd7;
        data_in = 8'hA5;
        raddr_a = 5'd7;
        raddr_b = 5'd8;
        tick();
        wen = 1'b0;
        tests++;
        if (a0 !== 8'hA5 || b0 !== 8'd18) begin
            fails++;
            $display("FAIL bypass: a=%h b=%h, required a=a5 b=12", a0, b0);
        end
        raddr_b = 5'd7;
        tick();
        tests++;
        if (a0 !== 8'hA5 || b0 !== 8'hA5) begin
            fails++;
            $display("FAIL bypass_stored: a=%h b=%h, required a5", a0, b0);
        end
    endtask

    // A one-cycle reset at clear cycle 20 restarts the full 32-cycle sequence and blocks user writes.
    task automatic test_reset_mid_clear();
        int cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wen = 1'b1;
        waddr = 5'd5;
        data_in = 8'h77;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        tests++;
        if (busy0 !== 1'b1 || a0 !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_state: busy=%b a=%h, required busy=1 a=00", busy0, a0);
        end
        reset = 1'b0;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        wen = 1'b0;
        tests++;
        if (cnt !== 32) begin
            fails++;
            $display("FAIL mid_reset_busy: %0d cycles, required 32", cnt);
        end
        raddr_a = 5'd5;
        raddr_b = 5'd31;
        tick();
        tests++;
        if (a0 !== 8'h00 || b0 !== 8'h00 || a1 !== 8'h3C || b1 !== 8'h3C) begin
            fails++;
            $display("FAIL mid_reset_cleared: a0=%h b0=%h a1=%h b1=%h, required 00/00/3c/3c", a0, b0, a1, b1);
        end
    endtask

    // 16-bit x 8-entry instance: 8-cycle clear and a 0xBEEF round-trip at address 7.
    task automatic test_param();
        int cnt;
        reset2 = 1'b1;
        tick();
        tick();
        reset2 = 1'b0;
        cnt = 0;
        while (busy2 === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        tests++;
        if (cnt !== 8) begin
            fails++;
            $display("FAIL param_busy: %0d cycles, required 8", cnt);
        end
        wen2 = 1'b1;
        waddr2 = 3'd7;
        din2 = 16'hBEEF;
        ra2 = 3'd0;
        rb2 = 3'd0;
        tick();
        wen2 = 1'b0;
        tests++;
        if (a2 !== 16'h0000 || b2 !== 16'h0000) begin
            fails++;
            $display("FAIL param_init: a=%h b=%h, required 0000", a2, b2);
        end
        ra2 = 3'd7;
        rb2 = 3'd7;
        tick();
        tests++;
        if (a2 !== 16'hBEEF || b2 !== 16'hBEEF) begin
            fails++;
            $display("FAIL param_roundtrip: a=%h b=%h, required beef", a2, b2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_reset_mid_clear();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
